// File: rtl/knn_multi_sorter.sv
// rtl/knn_multi_sorter.sv - parallel K-nearest-neighbour sorter for the KNN peripheral
//
// Holds N_TEST 2-D test points, each with its own list of the K nearest labelled
// data points seen during a run. Data points pass through a two-stage distance
// pipeline (difference, then sum of squares). Every list then takes the new point
// by single-cycle sorted insertion.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_we/cfg_idx/cfg_x/cfg_y   test point write (honoured in IDLE/DONE only)
//   start                        clear all lists and begin a run (IDLE/DONE only)
//   dp_valid/dp_ready/dp_x/dp_y/dp_label/dp_last
//                                data point stream, dp_last closes the run
//   busy, done                   run in progress / results stable
//   rd_test/rd_rank              combinational result read select
//   rd_valid/rd_label/rd_dist    selected list entry (zero when out of range)
module knn_multi_sorter #(
    parameter int K      = 4,
    parameter int N_TEST = 4,
    parameter int C_W    = 16,
    parameter int LBL_W  = 8,
    localparam int DIST_W = 2*C_W+3,
    localparam int TI_W   = (N_TEST > 1) ? $clog2(N_TEST) : 1,
    localparam int RK_W   = (K > 1) ? $clog2(K) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [TI_W-1:0]   cfg_idx,
    input  logic [C_W-1:0]    cfg_x,
    input  logic [C_W-1:0]    cfg_y,
    input  logic              start,
    input  logic              dp_valid,
    output logic              dp_ready,
    input  logic [C_W-1:0]    dp_x,
    input  logic [C_W-1:0]    dp_y,
    input  logic [LBL_W-1:0]  dp_label,
    input  logic              dp_last,
    output logic              busy,
    output logic              done,
    input  logic [TI_W-1:0]   rd_test,
    input  logic [RK_W-1:0]   rd_rank,
    output logic              rd_valid,
    output logic [LBL_W-1:0]  rd_label,
    output logic [DIST_W-1:0] rd_dist
);

    localparam int SQ_W = 2*C_W+2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;
    logic   drain_cnt;
    logic   accept;
    logic   start_ok;
    logic   cfg_ok;

    assign accept   = dp_valid && dp_ready;
    assign cfg_ok   = (state == S_IDLE) || (state == S_DONE);
    assign start_ok = start && cfg_ok;

    // State register. DRAIN lasts exactly two cycles so the last accepted point
    // has left both pipeline stages and been inserted before DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (accept && dp_last) state_nxt = S_DRAIN;
            S_DRAIN:        if (drain_cnt) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dp_ready = (state == S_RUN);
        busy     = (state == S_RUN) || (state == S_DRAIN);
        done     = (state == S_DONE);
    end

    // Test points. Index match by loop so out-of-range indices write nothing.
    logic [C_W-1:0] tp_x [N_TEST];
    logic [C_W-1:0] tp_y [N_TEST];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_TEST; i++) begin
            if (rst) begin
                tp_x[i] <= '0;
                tp_y[i] <= '0;
            end else if (cfg_we && cfg_ok && (cfg_idx == TI_W'(i))) begin
                tp_x[i] <= cfg_x;
                tp_y[i] <= cfg_y;
            end
        end
    end

    // Stage 1: signed differences, one extra bit so they never wrap.
    logic              s1_valid;
    logic [LBL_W-1:0]  s1_label;
    logic signed [C_W:0] s1_dx [N_TEST];
    logic signed [C_W:0] s1_dy [N_TEST];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_label <= '0;
        end else begin
            s1_valid <= accept;
            s1_label <= dp_label;
        end
        for (int i = 0; i < N_TEST; i++) begin
            if (rst) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end else begin
                s1_dx[i] <= {dp_x[C_W-1], dp_x} - {tp_x[i][C_W-1], tp_x[i]};
                s1_dy[i] <= {dp_y[C_W-1], dp_y} - {tp_y[i][C_W-1], tp_y[i]};
            end
        end
    end

    // Stage 2: squared distance. Each square fits SQ_W-1 bits, the sum SQ_W.
    logic signed [SQ_W-1:0] sq_x [N_TEST];
    logic signed [SQ_W-1:0] sq_y [N_TEST];
    logic              s2_valid;
    logic [LBL_W-1:0]  s2_label;
    logic [DIST_W-1:0] s2_d [N_TEST];

    always_comb begin
        for (int i = 0; i < N_TEST; i++) begin
            sq_x[i] = SQ_W'(s1_dx[i]) * SQ_W'(s1_dx[i]);
            sq_y[i] = SQ_W'(s1_dy[i]) * SQ_W'(s1_dy[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_label <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_label <= s1_label;
        end
        for (int i = 0; i < N_TEST; i++) begin
            if (rst) s2_d[i] <= '0;
            else     s2_d[i] <= {1'b0, sq_x[i]} + {1'b0, sq_y[i]};
        end
    end

    // Sorted lists. gt[r] marks ranks the new point beats; invalid entries sort
    // last, so gt is monotonic and the insertion point is its first set bit.
    // Equal distances do not set gt, which keeps the earlier point ahead.
    logic              l_valid [N_TEST][K];
    logic [LBL_W-1:0]  l_label [N_TEST][K];
    logic [DIST_W-1:0] l_dist  [N_TEST][K];
    logic              n_valid [N_TEST][K];
    logic [LBL_W-1:0]  n_label [N_TEST][K];
    logic [DIST_W-1:0] n_dist  [N_TEST][K];
    logic              gt      [N_TEST][K];

    always_comb begin
        for (int i = 0; i < N_TEST; i++) begin
            for (int r = 0; r < K; r++) begin
                gt[i][r]      = !l_valid[i][r] || (l_dist[i][r] > s2_d[i]);
                n_valid[i][r] = l_valid[i][r];
                n_label[i][r] = l_label[i][r];
                n_dist[i][r]  = l_dist[i][r];
            end
            if (gt[i][0]) begin
                n_valid[i][0] = 1'b1;
                n_label[i][0] = s2_label;
                n_dist[i][0]  = s2_d[i];
            end
            for (int r = 1; r < K; r++) begin
                if (gt[i][r]) begin
                    if (gt[i][r-1]) begin
                        n_valid[i][r] = l_valid[i][r-1];
                        n_label[i][r] = l_label[i][r-1];
                        n_dist[i][r]  = l_dist[i][r-1];
                    end else begin
                        n_valid[i][r] = 1'b1;
                        n_label[i][r] = s2_label;
                        n_dist[i][r]  = s2_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_TEST; i++) begin
            for (int r = 0; r < K; r++) begin
                if (rst || start_ok) begin
                    l_valid[i][r] <= 1'b0;
                    l_label[i][r] <= '0;
                    l_dist[i][r]  <= '0;
                end else if (s2_valid) begin
                    l_valid[i][r] <= n_valid[i][r];
                    l_label[i][r] <= n_label[i][r];
                    l_dist[i][r]  <= n_dist[i][r];
                end
            end
        end
    end

    // Read port: select by match so out-of-range selects read as zero.
    always_comb begin
        rd_valid = 1'b0;
        rd_label = '0;
        rd_dist  = '0;
        for (int i = 0; i < N_TEST; i++) begin
            for (int r = 0; r < K; r++) begin
                if ((rd_test == TI_W'(i)) && (rd_rank == RK_W'(r))) begin
                    rd_valid = l_valid[i][r];
                    rd_label = l_label[i][r];
                    rd_dist  = l_dist[i][r];
                end
            end
        end
    end

endmodule

// File: tb/tb_knn_multi_sorter.sv
// tb/tb_knn_multi_sorter.sv - directed self-checking bench for knn_multi_sorter
module tb_knn_multi_sorter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [15:0] cfg_x, cfg_y;
    logic        start;
    logic        dp_valid;
    logic        dp_ready;
    logic [15:0] dp_x, dp_y;
    logic [7:0]  dp_label;
    logic        dp_last;
    logic        busy, done;
    logic [1:0]  rd_test, rd_rank;
    logic        rd_valid;
    logic [7:0]  rd_label;
    logic [34:0] rd_dist;

    int n_tests = 0;
    int n_fail  = 0;

    knn_multi_sorter dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .start(start),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_x(dp_x), .dp_y(dp_y),
        .dp_label(dp_label), .dp_last(dp_last),
        .busy(busy), .done(done),
        .rd_test(rd_test), .rd_rank(rd_rank),
        .rd_valid(rd_valid), .rd_label(rd_label), .rd_dist(rd_dist)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input int x, input int y);
        cfg_we  = 1'b1;
        cfg_idx = 2'(idx);
        cfg_x   = 16'(x);
        cfg_y   = 16'(y);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int lbl, input bit last);
        dp_valid = 1'b1;
        dp_x     = 16'(x);
        dp_y     = 16'(y);
        dp_label = 8'(lbl);
        dp_last  = last;
        check("dp_ready_in_run", dp_ready, 1);
        tick();
        dp_valid = 1'b0;
        dp_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("done_within_bound", done, 1);
    endtask

    task automatic entry(input int t, input int r, input bit v, input int lbl, input logic [63:0] d);
        @(negedge clk);
        rd_test = 2'(t);
        rd_rank = 2'(r);
        #1;
        check($sformatf("valid_t%0d_r%0d", t, r), rd_valid, v);
        check($sformatf("label_t%0d_r%0d", t, r), rd_label, 64'(lbl));
        check($sformatf("dist_t%0d_r%0d", t, r), rd_dist, d);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_idx = 0; cfg_x = 0; cfg_y = 0; start = 0;
        dp_valid = 0; dp_x = 0; dp_y = 0; dp_label = 0; dp_last = 0;
        rd_test = 0; rd_rank = 0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_dp_ready", dp_ready, 0);
        for (int r = 0; r < 4; r++) entry(0, r, 0, 0, 0);
        entry(3, 3, 0, 0, 0);

        // basic run, exact done latency
        tick();
        cfg(0, 0, 0);
        pulse_start();
        check("run_busy", busy, 1);
        send(3, 4, 1, 0);
        send(1, 1, 2, 0);
        send(-2, 0, 3, 0);
        send(10, 0, 4, 0);
        send(0, 1, 5, 1);
        check("drain1_done", done, 0);
        check("drain1_busy", busy, 1);
        check("drain1_dp_ready", dp_ready, 0);
        tick();
        check("drain2_done", done, 0);
        tick();
        check("done_at_t3", done, 1);
        check("done_busy", busy, 0);
        entry(0, 0, 1, 5, 1);
        entry(0, 1, 1, 2, 2);
        entry(0, 2, 1, 3, 4);
        entry(0, 3, 1, 1, 25);
        check("done_holds", done, 1);

        // ties keep arrival order
        tick();
        pulse_start();
        check("restart_done_low", done, 0);
        send(1, 0, 7, 0);
        send(0, 1, 8, 0);
        send(-1, 0, 9, 1);
        wait_done();
        entry(0, 0, 1, 7, 1);
        entry(0, 1, 1, 8, 1);
        entry(0, 2, 1, 9, 1);
        entry(0, 3, 0, 0, 0);

        // coordinate extremes, single point run
        tick();
        cfg(0, -32768, -32768);
        pulse_start();
        send(32767, 32767, 1, 1);
        wait_done();
        entry(0, 0, 1, 1, 64'd8589672450);
        entry(0, 1, 0, 0, 0);

        // four lists, gaps, ignored start during RUN
        tick();
        cfg(0, 0, 0);
        cfg(1, 10, 0);
        cfg(2, -5, 5);
        cfg(3, 100, 100);
        pulse_start();
        send(3, 4, 1, 0);
        tick();
        send(1, 1, 2, 0);
        pulse_start();
        check("start_ignored_busy", busy, 1);
        check("start_ignored_ready", dp_ready, 1);
        send(-2, 0, 3, 0);
        tick(); tick();
        send(10, 0, 4, 0);
        send(0, 1, 5, 1);
        wait_done();
        entry(0, 0, 1, 5, 1);     entry(0, 1, 1, 2, 2);
        entry(0, 2, 1, 3, 4);     entry(0, 3, 1, 1, 25);
        entry(1, 0, 1, 4, 0);     entry(1, 1, 1, 1, 65);
        entry(1, 2, 1, 2, 82);    entry(1, 3, 1, 5, 101);
        entry(2, 0, 1, 3, 34);    entry(2, 1, 1, 5, 41);
        entry(2, 2, 1, 2, 52);    entry(2, 3, 1, 1, 65);
        entry(3, 0, 1, 4, 18100); entry(3, 1, 1, 1, 18625);
        entry(3, 2, 1, 2, 19602); entry(3, 3, 1, 5, 19801);

        // reset mid-run, then a short run with cfg_we during RUN
        tick();
        pulse_start();
        for (int p = 0; p < 5; p++) send(p, 2 * p, 20 + p, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dp_ready", dp_ready, 0);
        entry(0, 0, 0, 0, 0);
        tick();
        cfg(0, 0, 0);
        pulse_start();
        cfg(0, 50, 50);
        send(2, 0, 11, 0);
        send(0, 3, 12, 1);
        wait_done();
        entry(0, 0, 1, 11, 4);
        entry(0, 1, 1, 12, 9);
        entry(0, 2, 0, 0, 0);
        entry(1, 0, 1, 11, 4);
        entry(1, 1, 1, 12, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
